dac_sample_scheduler: RTL and testbench
=======================================

# dac_sample_scheduler

Paces and arbitrates 10-bit sample traffic onto the `avsddac` D bus. The block takes two requesters: port 0 is the `rvmyth` core output stream and port 1 is a test/waveform source. It grants them round-robin and holds each accepted code on the DAC for a programmable number of PLL clock cycles. It sits between `rvmyth`/test logic and `avsddac` inside `vsdbabysoc`, clocked by the PLL output.

## Interface
- WIDTH, 10, sample/DAC code width
- DIV_W, 8, width of the hold-period configuration
- MIDSCALE, 10'h200, DAC code driven from reset until the first accepted sample
- clk  input  1  PLL clock (`CLK` net at top level)
- reset  input  1  asynchronous, active-low reset: low clears all state immediately; release is synchronous to `clk`
- cfg_en  input  1  scheduler enable; gates new grants only
- cfg_div  input  DIV_W  hold period minus one; sampled on HOLD entry
- valid0, valid1  input  1 each  requester has a sample
- data0, data1  input  WIDTH each  requester sample
- ready0, ready1  output  1 each  grant; transfer when validN && readyN
- dac_d  output  WIDTH  registered code to `avsddac` D
- sample_strobe  output  1  one-cycle pulse when dac_d takes a new value
- underrun  output  1  one-cycle pulse on a missed sample slot
- underrun_cnt  output  8  saturating underrun count

## Operation
- **Reset values:**
  - dac_d=MIDSCALE; sample_strobe=0; ready0=ready1=0; underrun=0; underrun_cnt=0.
  - state=IDLE; last_gnt=1, so port 0 wins the first tie.
- **States:** IDLE, LOAD, HOLD.
- **IDLE → LOAD:**
  - Taken when cfg_en=1 and (valid0 or valid1).
  - Grant choice is registered: if both are valid, the port ≠ last_gnt; otherwise the single valid port.
- **LOAD:**
  - Exactly one of ready0/ready1 is high, for this one cycle only.
  - If the granted valid is high: transfer occurs, dac_d ← granted data at the clock edge, sample_strobe=1 the following cycle, last_gnt ← granted port, next state HOLD.
  - If the granted valid dropped (protocol violation): no transfer, dac_d and last_gnt are unchanged, next state IDLE.
- **HOLD:**
  - On entry, the counter is loaded with cfg_div. It decrements each cycle, and the state moves to IDLE when the counter reads 0.
  - HOLD therefore lasts cfg_div+1 cycles. cfg_div changes during HOLD are ignored.
- **cfg_en=0:**
  - Blocks only the IDLE→LOAD transition.
  - A LOAD or HOLD in progress completes normally. dac_d holds its last value indefinitely.
- **Underrun:**
  - Raised in the first IDLE cycle after HOLD when cfg_en=1 and neither valid is high.
  - underrun pulses for one cycle, and underrun_cnt increments, saturating at 255.
  - No underrun is raised when cfg_en=0.
- **Value retention:** dac_d is never changed except by a transfer or by reset.

## Timing
- Valid seen in IDLE at cycle t → ready high at t+1 → dac_d/strobe at t+2 → HOLD from t+2 to t+2+cfg_div → IDLE at t+3+cfg_div.
- Continuous-demand sample period is cfg_div+3 cycles. The minimum is 3 cycles, at cfg_div=0.
- ready depends only on registered state (no combinational path from valid to ready).
- Reset asserted mid-LOAD or mid-HOLD:
  - All outputs take their reset values immediately, including dac_d=MIDSCALE and ready=0.
  - No transfer is counted.
- Both valids high continuously → grants alternate 0,1,0,1…; a single persistent requester is granted every period.

## Structure
- Package `dac_sched_pkg` contains:
  - the state enum {IDLE, LOAD, HOLD};
  - the MIDSCALE constant;
  - the default WIDTH/DIV_W values.
- Sub-module `rr_arb2` holds the 2-way round-robin pick. It is combinational from valid0, valid1 and last_gnt, and outputs the port index plus an any-valid flag.
- The top of `dac_sample_scheduler` contains the FSM, hold counter, dac_d register and underrun counter.

## Test plan
- **Reset and enable:**
  - Stimulus: reset low; then release with cfg_en=0 and valid0=1.
  - Required: dac_d=10'h200, no ready ever, no underrun pulses.
- **Single transfer:**
  - Stimulus: cfg_en=1, cfg_div=4, valid0 with data0=10'h155 at t.
  - Required: ready0 at t+1; dac_d=10'h155 with strobe at t+2; next ready at t+8 (period 7).
- **Round-robin fairness:**
  - Stimulus: both valids held, data0=10'h0AA, data1=10'h3FF.
  - Required: dac_d sequence 0AA, 3FF, 0AA, 3FF; ready0/ready1 never high together.
- **Underrun counting:**
  - Stimulus: a single sample, then valids held low with cfg_en=1.
  - Required: exactly one underrun pulse, underrun_cnt=1, dac_d held.
  - Stimulus: 300 forced underruns.
  - Required: underrun_cnt saturates at 255.
- **Mid-operation events:**
  - Stimulus: reset asserted during HOLD with cfg_div=200.
  - Required: dac_d returns to 10'h200 immediately.
  - Stimulus: valid1 withdrawn during LOAD.
  - Required: no strobe, FSM back to IDLE, and the next tie goes to the same port as before.

Source files
------------

// File: rtl/dac_sched_pkg.sv
// Shared types and defaults for the DAC sample scheduler.
package dac_sched_pkg;

  localparam int WIDTH_DEF = 10;
  localparam int DIV_W_DEF = 8;
  localparam logic [WIDTH_DEF-1:0] MIDSCALE_DEF = 10'h200;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } sched_state_t;

endpackage

// File: rtl/dac_sample_scheduler_rr_arb2.sv
// Two-way round-robin pick: on a tie the port that was not granted last wins.
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_gnt,
  output logic pick,
  output logic any_valid
);

  always_comb begin
    any_valid = valid0 | valid1;
    if (valid0 && valid1) pick = ~last_gnt;
    else                  pick = valid1;
  end

endmodule

// File: rtl/dac_sample_scheduler.sv
// Paces two sample requesters onto the DAC D bus, holding each code cfg_div+1 cycles.
// state | meaning
// IDLE  | waiting for enable and a valid requester
// LOAD  | one-cycle grant; transfer if the granted valid is still high
// HOLD  | code held on dac_d while hold_cnt runs down to zero
module dac_sample_scheduler
  import dac_sched_pkg::*;
#(
  parameter int               WIDTH    = WIDTH_DEF,
  parameter int               DIV_W    = DIV_W_DEF,
  parameter logic [WIDTH-1:0] MIDSCALE = WIDTH'(MIDSCALE_DEF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_en,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             valid0,
  input  logic             valid1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             ready0,
  output logic             ready1,
  output logic [WIDTH-1:0] dac_d,
  output logic             sample_strobe,
  output logic             underrun,
  output logic [7:0]       underrun_cnt
);

  localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

  sched_state_t     state;
  logic             gnt;
  logic             last_gnt;
  logic             after_hold;
  logic [DIV_W-1:0] hold_cnt;
  logic             pick;
  logic             any_valid;
  logic             gnt_valid;

  rr_arb2 u_arb (
    .valid0    (valid0),
    .valid1    (valid1),
    .last_gnt  (last_gnt),
    .pick      (pick),
    .any_valid (any_valid)
  );

  assign gnt_valid = gnt ? valid1 : valid0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      gnt           <= 1'b0;
      last_gnt      <= 1'b1;
      after_hold    <= 1'b0;
      hold_cnt      <= '0;
      ready0        <= 1'b0;
      ready1        <= 1'b0;
      dac_d         <= MIDSCALE;
      sample_strobe <= 1'b0;
      underrun      <= 1'b0;
      underrun_cnt  <= 8'd0;
    end else begin
      sample_strobe <= 1'b0;
      underrun      <= 1'b0;
      case (state)
        IDLE: begin
          after_hold <= 1'b0;
          if (cfg_en && any_valid) begin
            gnt    <= pick;
            ready0 <= ~pick;
            ready1 <= pick;
            state  <= LOAD;
          end else if (cfg_en && after_hold) begin
            // only the first idle slot after a hold counts as a missed sample
            underrun <= 1'b1;
            if (underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
          end
        end
        LOAD: begin
          ready0 <= 1'b0;
          ready1 <= 1'b0;
          if (gnt_valid) begin
            dac_d         <= gnt ? data1 : data0;
            sample_strobe <= 1'b1;
            last_gnt      <= gnt;
            hold_cnt      <= cfg_div;
            state         <= HOLD;
          end else begin
            state <= IDLE;
          end
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            after_hold <= 1'b1;
            state      <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Directed bench with an expected-code scoreboard popped on every sample strobe.
module tb_dac_sample_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_en;
  logic [7:0] cfg_div;
  logic       valid0, valid1;
  logic [9:0] data0, data1;
  logic       ready0, ready1;
  logic [9:0] dac_d;
  logic       sample_strobe;
  logic       underrun;
  logic [7:0] underrun_cnt;

  int checks = 0;
  int errors = 0;
  int ur_pulses = 0;
  int strobe_cnt = 0;
  int ready_seen = 0;
  logic [9:0] exp_q[$];

  dac_sample_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_en        (cfg_en),
    .cfg_div       (cfg_div),
    .valid0        (valid0),
    .valid1        (valid1),
    .data0         (data0),
    .data1         (data1),
    .ready0        (ready0),
    .ready1        (ready1),
    .dac_d         (dac_d),
    .sample_strobe (sample_strobe),
    .underrun      (underrun),
    .underrun_cnt  (underrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (sample_strobe) begin
        strobe_cnt++;
        if (exp_q.size() == 0) chk("strobe_unexpected", 32'd1, 32'd0);
        else chk("dac_d_scoreboard", 32'(dac_d), 32'(exp_q.pop_front()));
      end
      if (ready0 || ready1) begin
        ready_seen++;
        chk("ready_onehot", 32'(ready0 & ready1), 32'd0);
      end
      if (underrun) ur_pulses++;
    end
  end

  task automatic wait_strobe(input string tag, input int limit);
    int n = 0;
    do begin @(negedge clk); n++; end while (!sample_strobe && n < limit);
    chk(tag, 32'(sample_strobe), 32'd1);
  endtask

  task automatic wait_ready(input string tag, input int limit);
    int n = 0;
    do begin @(negedge clk); n++; end while (!(ready0 || ready1) && n < limit);
    chk(tag, 32'(ready0 | ready1), 32'd1);
  endtask

  task automatic wait_underrun(input string tag, input int limit);
    int n = 0;
    do begin @(negedge clk); n++; end while (!underrun && n < limit);
    chk(tag, 32'(underrun), 32'd1);
  endtask

  initial begin
    int n;
    int u0;
    reset = 1'b0; cfg_en = 1'b0; cfg_div = 8'd0;
    valid0 = 1'b1; valid1 = 1'b0; data0 = 10'h123; data1 = 10'h000;

    // reset state, then enable held off
    #22;
    chk("rst_dac_d", 32'(dac_d), 32'h200);
    chk("rst_ready", 32'({ready0, ready1}), 32'd0);
    chk("rst_underrun_cnt", 32'(underrun_cnt), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("disabled_no_ready", 32'(ready_seen), 32'd0);
    chk("disabled_no_underrun", 32'(ur_pulses), 32'd0);
    chk("disabled_dac_d", 32'(dac_d), 32'h200);

    // single transfer timing, period 7, then one underrun
    @(posedge clk); #1;
    cfg_en = 1'b1; cfg_div = 8'd4; data0 = 10'h155;
    exp_q.push_back(10'h155); exp_q.push_back(10'h155);
    @(negedge clk);
    @(negedge clk);
    chk("t1_ready0", 32'(ready0), 32'd1);
    chk("t1_ready1", 32'(ready1), 32'd0);
    @(negedge clk);
    chk("t2_dac_d", 32'(dac_d), 32'h155);
    chk("t2_strobe", 32'(sample_strobe), 32'd1);
    n = 0;
    do begin @(negedge clk); n++; end while (!ready0 && n < 20);
    chk("next_ready_t8", 32'(n), 32'd6);
    wait_strobe("second_strobe", 5);
    u0 = ur_pulses;
    @(posedge clk); #1 valid0 = 1'b0;
    repeat (15) @(negedge clk);
    chk("underrun_one_pulse", 32'(ur_pulses - u0), 32'd1);
    chk("underrun_cnt_1", 32'(underrun_cnt), 32'd1);
    chk("underrun_dac_held", 32'(dac_d), 32'h155);

    // reset in the middle of a long hold
    @(posedge clk); #1;
    cfg_div = 8'd200; data1 = 10'h2C3; valid1 = 1'b1;
    exp_q.push_back(10'h2C3);
    wait_strobe("long_hold_strobe", 10);
    @(posedge clk); #1 valid1 = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midhold_rst_dac_d", 32'(dac_d), 32'h200);
    chk("midhold_rst_ready", 32'({ready0, ready1}), 32'd0);
    chk("midhold_rst_strobe", 32'(sample_strobe), 32'd0);
    chk("midhold_rst_ucnt", 32'(underrun_cnt), 32'd0);
    chk("midhold_queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1 reset = 1'b1; cfg_div = 8'd1;

    // round-robin with both requesters held
    @(posedge clk); #1;
    data0 = 10'h0AA; data1 = 10'h3FF; valid0 = 1'b1; valid1 = 1'b1;
    exp_q.push_back(10'h0AA); exp_q.push_back(10'h3FF);
    exp_q.push_back(10'h0AA); exp_q.push_back(10'h3FF);
    u0 = strobe_cnt;
    n = 0;
    while ((strobe_cnt - u0) < 4 && n < 60) begin @(negedge clk); n++; end
    chk("rr_four_strobes", 32'(strobe_cnt - u0), 32'd4);
    @(posedge clk); #1 valid0 = 1'b0; valid1 = 1'b0;
    repeat (4) @(posedge clk);

    // withdrawal during LOAD leaves last_gnt unchanged
    #1 data0 = 10'h011; valid0 = 1'b1;
    exp_q.push_back(10'h011);
    wait_strobe("solo0_strobe", 10);
    @(posedge clk); #1 valid0 = 1'b0;
    repeat (6) @(posedge clk);
    #1 data0 = 10'h0F0; data1 = 10'h30F; valid0 = 1'b1; valid1 = 1'b1;
    wait_ready("withdraw_ready", 5);
    chk("withdraw_gnt1", 32'({ready0, ready1}), 32'b01);
    valid0 = 1'b0; valid1 = 1'b0;
    @(negedge clk);
    chk("withdraw_no_strobe", 32'(sample_strobe), 32'd0);
    chk("withdraw_no_ready", 32'({ready0, ready1}), 32'd0);
    chk("withdraw_dac_held", 32'(dac_d), 32'h011);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 valid0 = 1'b1; valid1 = 1'b1;
    exp_q.push_back(10'h30F);
    wait_ready("retie_ready", 5);
    chk("retie_gnt1", 32'({ready0, ready1}), 32'b01);
    wait_strobe("retie_strobe", 5);
    @(posedge clk); #1 valid0 = 1'b0; valid1 = 1'b0;
    repeat (4) @(posedge clk);

    // 300 forced underruns saturate the counter
    #1 cfg_div = 8'd0;
    u0 = ur_pulses;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      data0 = 10'(i) ^ 10'h155; valid0 = 1'b1;
      exp_q.push_back(10'(i) ^ 10'h155);
      wait_strobe("sat_strobe", 6);
      @(posedge clk); #1 valid0 = 1'b0;
      wait_underrun("sat_underrun", 6);
    end
    repeat (3) @(negedge clk);
    chk("sat_pulses", 32'(ur_pulses - u0), 32'd300);
    chk("sat_cnt_255", 32'(underrun_cnt), 32'd255);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
